// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for pulse_gen_param: FSM states, mode encodings,
// and the burst-length normalisation helper.
package pulse_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_CONT   = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;

    // Widest burst_len the helper can normalise; the top checks BURST_W against it.
    localparam int MAX_BURST_W = 16;

    // A burst length of zero means one pulse.
    function automatic logic [MAX_BURST_W-1:0] burst_eff(input logic [MAX_BURST_W-1:0] len);
        return (len == '0) ? MAX_BURST_W'(1) : len;
    endfunction

endpackage

// File: rtl/pulse_gen_param_rise_detect.sv
// Registered rising-edge detector; the history flop resets to rst_val so a
// level already high at reset release can be masked.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= rst_val;
        else        sig_q <= sig;
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/pulse_gen_param.sv
// Parametrised pulse-train generator: single, continuous and burst modes with
// abort and busy/done status. Define PULSE_GEN_RETRIG_EN to restart on a trigger in RUN.
module pulse_gen_param
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W   = 6,
    parameter int DELAY   = 10,
    parameter int HIGH    = 5,
    parameter int PERIOD  = 40,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init,
    input  logic [1:0]         mode,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               stop,
    output logic               pulse,
    output logic               busy,
    output logic               done
);

    if (HIGH < 1 || PERIOD < 1 || DELAY < 0 || DELAY + HIGH > PERIOD ||
        PERIOD > (1 << CNT_W) || BURST_W > MAX_BURST_W) begin : g_bad_cfg
        $error("pulse_gen_param: illegal timing or width parameters");
    end

    localparam logic [CNT_W-1:0] END_CNT = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W:0]   WIN_LO  = (CNT_W + 1)'(DELAY);
    localparam logic [CNT_W:0]   WIN_HI  = (CNT_W + 1)'(DELAY + HIGH);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [BURST_W-1:0] pcnt, pcnt_d, pcnt_inc;
    logic [1:0]         mode_q, mode_d;
    logic [BURST_W-1:0] blen_q, blen_d;
    logic               pulse_d, done_d;
    logic               trig, period_end, last_period;

    rise_detect u_rise (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val (1'b1),
        .sig     (init),
        .rise    (trig)
    );

    assign period_end  = (cnt == END_CNT);
    assign pcnt_inc    = pcnt + 1'b1;
    // Continuous never finishes; reserved mode falls into the single-period case.
    assign last_period = (mode_q != MODE_CONT) &&
                         ((mode_q != MODE_BURST) ||
                          (MAX_BURST_W'(pcnt_inc) == burst_eff(MAX_BURST_W'(blen_q))));

    // NOTE: every output of this block gets a default first so no latches are inferred.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pcnt_d  = pcnt;
        mode_d  = mode_q;
        blen_d  = blen_q;
        done_d  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (trig && !stop) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                    mode_d  = mode;
                    blen_d  = burst_len;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                end else if (period_end && last_period) begin
                    // Normal completion beats a coincident trigger.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                    done_d  = 1'b1;
`ifdef PULSE_GEN_RETRIG_EN
                end else if (trig) begin
                    cnt_d  = '0;
                    pcnt_d = '0;
                    mode_d = mode;
                    blen_d = burst_len;
`endif
                end else if (period_end) begin
                    cnt_d = '0;
                    if (mode_q == MODE_BURST) pcnt_d = pcnt_inc;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pulse_d = (state_d == ST_RUN) &&
                  ({1'b0, cnt_d} >= WIN_LO) && ({1'b0, cnt_d} < WIN_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            pcnt   <= '0;
            mode_q <= MODE_SINGLE;
            blen_q <= '0;
            pulse  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            pcnt   <= pcnt_d;
            mode_q <= mode_d;
            blen_q <= blen_d;
            pulse  <= pulse_d;
            busy   <= (state_d == ST_RUN);
            done   <= done_d;
        end
    end

endmodule

// File: tb/tb_pulse_gen_param.sv
// Directed self-checking bench for pulse_gen_param with default parameters.
// Expectations for the retrigger case follow PULSE_GEN_RETRIG_EN when defined.
module tb_pulse_gen_param;

    localparam int D = 10;
    localparam int H = 5;
    localparam int P = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init;
    logic [1:0] mode;
    logic [3:0] burst_len;
    logic       stop;
    logic       pulse, busy, done;

    int tests_run = 0;
    int tests_failed = 0;

    logic p_log [0:199];
    logic b_log [0:199];
    logic d_log [0:199];

    pulse_gen_param dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .mode      (mode),
        .burst_len (burst_len),
        .stop      (stop),
        .pulse     (pulse),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic in_win(input int k);
        return ((k % P) >= D) && ((k % P) < D + H);
    endfunction

    // Raise init so the next edge is E0, then log outputs after edges 0..n-1.
    // Optional extra trigger / stop are sampled at edge index retrig_at / stop_at.
    task automatic run_train(input int n, input int stop_at, input int retrig_at,
                             input logic [1:0] m2, input logic [3:0] bl2);
        init = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            p_log[k] = pulse;
            b_log[k] = busy;
            d_log[k] = done;
            if (k == 0) begin
                mode      = m2;
                burst_len = bl2;
            end
            init = (k + 1 == retrig_at);
            stop = (k + 1 == stop_at);
        end
        init = 1'b0;
        stop = 1'b0;
    endtask

    task automatic compare_logs(input string name, input int n, input int busy_end,
                                input int done_at, input int second_start);
        logic ep, eb, ed;
        for (int k = 0; k < n; k++) begin
            eb = (k < busy_end);
            ed = (k == done_at);
            if (second_start >= 0 && k >= second_start) ep = eb && in_win(k - second_start);
            else ep = eb && in_win(k);
            tests_run += 3;
            if (p_log[k] !== ep) begin
                tests_failed++;
                $display("FAIL %s pulse@%0d got %b want %b", name, k, p_log[k], ep);
            end
            if (b_log[k] !== eb) begin
                tests_failed++;
                $display("FAIL %s busy@%0d got %b want %b", name, k, b_log[k], eb);
            end
            if (d_log[k] !== ed) begin
                tests_failed++;
                $display("FAIL %s done@%0d got %b want %b", name, k, d_log[k], ed);
            end
        end
    endtask

    task automatic idle_gap();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({pulse, busy, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_state got %b want 000", {pulse, busy, done});
        end
    endtask

    task automatic test_single();
        mode = 2'b00; burst_len = 4'd0;
        run_train(45, -1, -1, 2'b00, 4'd0);
        compare_logs("single", 45, P, P, -1);
        idle_gap();
    endtask

    task automatic test_reserved_mode();
        mode = 2'b11; burst_len = 4'd7;
        run_train(45, -1, -1, 2'b11, 4'd7);
        compare_logs("reserved", 45, P, P, -1);
        idle_gap();
    endtask

    task automatic test_continuous_stop();
        mode = 2'b01; burst_len = 4'd0;
        run_train(105, 100, -1, 2'b00, 4'd0);
        compare_logs("cont_stop", 105, 100, -1, -1);
        idle_gap();
    endtask

    task automatic test_burst();
        mode = 2'b10; burst_len = 4'd3;
        run_train(125, -1, -1, 2'b01, 4'd0);
        compare_logs("burst3", 125, 3 * P, 3 * P, -1);
        idle_gap();
        mode = 2'b10; burst_len = 4'd0;
        run_train(45, -1, -1, 2'b10, 4'd5);
        compare_logs("burst0", 45, P, P, -1);
        idle_gap();
    endtask

    task automatic test_retrigger();
        mode = 2'b00; burst_len = 4'd0;
        run_train(65, -1, 20, 2'b00, 4'd0);
`ifdef PULSE_GEN_RETRIG_EN
        compare_logs("retrig", 65, 60, 60, 20);
`else
        compare_logs("retrig", 65, P, P, -1);
`endif
        idle_gap();
    endtask

    task automatic test_back_to_back();
        mode = 2'b00; burst_len = 4'd0;
        run_train(50, -1, P, 2'b00, 4'd0);
        compare_logs("trig_at_end", 50, P, P, -1);
        idle_gap();
    endtask

    task automatic test_init_through_reset();
        init = 1'b1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if ({pulse, busy} !== 2'b00) begin
                tests_failed++;
                $display("FAIL init_held@%0d got %b want 00", k, {pulse, busy});
            end
        end
        init = 1'b0;
        idle_gap();
    endtask

    task automatic test_reset_mid_pulse();
        mode = 2'b00; burst_len = 4'd0;
        run_train(13, -1, -1, 2'b00, 4'd0);
        tests_run++;
        if ({p_log[12], b_log[12]} !== 2'b11) begin
            tests_failed++;
            $display("FAIL pre_reset got %b want 11", {p_log[12], b_log[12]});
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({pulse, busy, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL async_reset got %b want 000", {pulse, busy, done});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_gap();
    endtask

    task automatic test_stop_with_trigger();
        stop = 1'b1;
        init = 1'b1;
        mode = 2'b01;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) stop = 1'b0;
            tests_run++;
            if ({pulse, busy} !== 2'b00) begin
                tests_failed++;
                $display("FAIL stop_trig@%0d got %b want 00", k, {pulse, busy});
            end
        end
        init = 1'b0;
        idle_gap();
    endtask

    initial begin
        rst_n = 1'b0;
        init = 1'b0;
        mode = 2'b00;
        burst_len = 4'd0;
        stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        idle_gap();
        test_single();
        test_reserved_mode();
        test_continuous_stop();
        test_burst();
        test_retrigger();
        test_back_to_back();
        test_init_through_reset();
        test_reset_mid_pulse();
        test_stop_with_trigger();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
